// File: rtl/mha_arb_pkg.sv
// rtl/mha_arb_pkg.sv - shared state type and default sizing for the BRAM request arbiter
package mha_arb_pkg;

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_SEL_W   = 6;
  localparam int DEF_TIMEOUT = 64;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting one past the last grant
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] j;

  // Scan farthest-to-nearest so the nearest requester after last_grant overwrites the rest.
  always_comb begin
    gnt = '0;
    idx = '0;
    j   = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      j = IDX_W'((int'(last_grant) + i) % N_REQ);
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/bram_req_arbiter.sv
// rtl/bram_req_arbiter.sv - shares one BRAM tile loader among N_REQ requesters with timeout
module bram_req_arbiter
  import mha_arb_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int SEL_W   = DEF_SEL_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                          I_CLK,
  input  logic                          I_RST_N,
  input  logic [N_REQ-1:0]              I_REQ,
  input  logic [0:N_REQ-1][SEL_W-1:0]   I_SEL,
  output logic [N_REQ-1:0]              O_GNT,
  output logic [N_REQ-1:0]              O_DONE,
  output logic                          O_BUSY,
  output logic                          O_ERR,
  input  logic                          I_ERR_CLR,
  output logic                          O_MGR_VLD_PULSE,
  output logic [SEL_W-1:0]              O_MGR_SEL,
  input  logic                          I_MGR_VLD
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t           state, state_nxt;
  logic [N_REQ-1:0] gnt_nxt, done_nxt, rr_gnt;
  logic [IDX_W-1:0] last_grant, last_grant_nxt, win_idx, win_idx_nxt, rr_idx;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [SEL_W-1:0] sel_nxt;
  logic             busy_nxt, err_nxt, pulse_nxt, vld_d, rise;

  rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr (
    .req        (I_REQ),
    .last_grant (last_grant),
    .gnt        (rr_gnt),
    .idx        (rr_idx)
  );

  // Only a fresh edge completes; a level left high by the previous load is ignored.
  assign rise = I_MGR_VLD & ~vld_d;

  always_comb begin
    state_nxt      = state;
    gnt_nxt        = O_GNT;
    done_nxt       = '0;
    busy_nxt       = O_BUSY;
    err_nxt        = O_ERR;
    pulse_nxt      = 1'b0;
    sel_nxt        = O_MGR_SEL;
    cnt_nxt        = cnt;
    last_grant_nxt = last_grant;
    win_idx_nxt    = win_idx;
    if (I_ERR_CLR) err_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        if (|I_REQ) begin
          gnt_nxt     = rr_gnt;
          win_idx_nxt = rr_idx;
          sel_nxt     = I_SEL[rr_idx];
          pulse_nxt   = 1'b1;
          busy_nxt    = 1'b1;
          cnt_nxt     = '0;
          state_nxt   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (rise) begin
          done_nxt  = O_GNT;
          gnt_nxt   = '0;
          state_nxt = S_DONE;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          err_nxt   = 1'b1;
          done_nxt  = O_GNT;
          gnt_nxt   = '0;
          state_nxt = S_DONE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_DONE: begin
        busy_nxt       = 1'b0;
        last_grant_nxt = win_idx;
        state_nxt      = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state           <= S_IDLE;
      O_GNT           <= '0;
      O_DONE          <= '0;
      O_BUSY          <= 1'b0;
      O_ERR           <= 1'b0;
      O_MGR_VLD_PULSE <= 1'b0;
      O_MGR_SEL       <= '0;
      vld_d           <= 1'b0;
      cnt             <= '0;
      last_grant      <= IDX_W'(N_REQ - 1);
      win_idx         <= '0;
    end else begin
      state           <= state_nxt;
      O_GNT           <= gnt_nxt;
      O_DONE          <= done_nxt;
      O_BUSY          <= busy_nxt;
      O_ERR           <= err_nxt;
      O_MGR_VLD_PULSE <= pulse_nxt;
      O_MGR_SEL       <= sel_nxt;
      vld_d           <= I_MGR_VLD;
      cnt             <= cnt_nxt;
      last_grant      <= last_grant_nxt;
      win_idx         <= win_idx_nxt;
    end
  end

endmodule

// File: doc/bram_req_arbiter.md
BRAM_REQ_ARBITER -- requirements
Module: bram_req_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters sharing one BRAM tile loader.
REQ-002 SHALL have parameter SEL_W, default 6: tile-select width (64 tiles).
REQ-003 SHALL have parameter TIMEOUT, default 64: maximum wait cycles for loader completion.
REQ-004 SHALL have port I_CLK  input  1  clock, rising edge.
REQ-005 SHALL have port I_RST_N  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port I_REQ  input  N_REQ  per-requester load request, level.
REQ-007 SHALL have port I_SEL  input  [0:N_REQ-1][SEL_W-1:0]  per-requester tile select.
REQ-008 SHALL have port O_GNT  output  N_REQ  one-hot grant, held for the whole transaction.
REQ-009 SHALL have port O_DONE  output  N_REQ  one-cycle completion pulse to the granted requester.
REQ-010 SHALL have port O_BUSY  output  1  high while a transaction is in flight.
REQ-011 SHALL have port O_ERR  output  1  sticky timeout flag.
REQ-012 SHALL have port I_ERR_CLR  input  1  clears O_ERR.
REQ-013 SHALL have port O_MGR_VLD_PULSE  output  1  single-cycle start pulse to the tile loader.
REQ-014 SHALL have port O_MGR_SEL  output  SEL_W  tile select to the loader, held stable from issue to completion.
REQ-015 SHALL have port I_MGR_VLD  input  1  loader valid level; completion is its rising edge.

Function
REQ-016 SHALL implement states S_IDLE, S_WAIT, S_DONE; all outputs registered.
REQ-017 In S_IDLE with any I_REQ bit set, SHALL, at the edge: set O_GNT to the round-robin winner, latch O_MGR_SEL from that winner's I_SEL, assert O_MGR_VLD_PULSE for exactly the next cycle, set O_BUSY, clear the wait counter, and enter S_WAIT.
REQ-018 Round-robin SHALL search from last_grant+1 upward, modulo N_REQ; last_grant resets to N_REQ-1, so requester 0 has first priority.
REQ-019 In S_WAIT, SHALL deassert O_MGR_VLD_PULSE and detect completion as I_MGR_VLD==1 while vld_d==0; vld_d is I_MGR_VLD registered every cycle.
REQ-020 A stale high I_MGR_VLD left over from a previous load SHALL NOT count as completion; only a new rising edge counts.
REQ-021 On completion, SHALL pulse O_DONE[winner] for 1 cycle, clear O_GNT, and enter S_DONE.
REQ-022 S_DONE SHALL last exactly 1 cycle: clear O_BUSY, update last_grant, then go to S_IDLE; this gives the requester one edge to drop I_REQ.
REQ-023 Wait counter SHALL increment each S_WAIT cycle; reaching TIMEOUT-1 without completion SHALL set O_ERR, pulse O_DONE[winner], and enter S_DONE.
REQ-024 Completion and timeout in the same cycle SHALL be treated as completion; O_ERR is not set.
REQ-025 O_ERR SHALL clear on I_ERR_CLR; simultaneous set and clear: set wins.
REQ-026 I_REQ changes or I_SEL changes during S_WAIT/S_DONE SHALL be ignored; the transaction completes unchanged.
REQ-027 Nominal latency: start pulse 1 cycle after request sampled; O_DONE 1 cycle after the I_MGR_VLD rising edge.
REQ-028 Back-to-back: with I_REQ still high, next grant no earlier than 1 cycle after S_DONE (3-cycle minimum gap between pulses beyond loader time).

Reset
REQ-029 On I_RST_N low, SHALL asynchronously force: state S_IDLE, O_GNT=0, O_DONE=0, O_BUSY=0, O_ERR=0, O_MGR_VLD_PULSE=0, O_MGR_SEL=0, vld_d=0, counter=0, last_grant=N_REQ-1.
REQ-030 Reset mid-transaction SHALL abort silently, with no O_DONE pulse emitted.

Structure
REQ-031 Package mha_arb_pkg SHALL hold the state enum, N_REQ, SEL_W and TIMEOUT defaults.
REQ-032 Round-robin selection SHALL be a combinational sub-module rr_arbiter (inputs req, last_grant; output one-hot gnt plus index).

Verification
REQ-033 Single request: I_REQ=4'b0001, I_SEL[0]=6'd5, loader VLD rise 6 cycles after pulse -> one pulse with O_MGR_SEL=5, O_GNT=0001, O_DONE[0] one cycle after the rise.
REQ-034 Fairness: I_REQ=4'b1111 held for 4 transactions -> grant order 0,1,2,3, with exactly one pulse each.
REQ-035 Stale VLD: I_MGR_VLD held high before the pulse, falls 1 cycle after, rises 5 cycles later -> O_DONE only after the new rise.
REQ-036 Timeout: I_MGR_VLD stuck low -> O_ERR=1 and O_DONE pulse on wait cycle 63; I_ERR_CLR then clears O_ERR.
REQ-037 Reset mid-S_WAIT: I_RST_N low for 1 cycle -> all outputs 0, no O_DONE, next I_REQ=4'b0010 granted to requester 0 priority order (gets 1).
REQ-038 Request churn: I_SEL[2] changed from 3 to 9 during S_WAIT -> O_MGR_SEL stays 3 until O_DONE.
